// File: rtl/countdown_pkg.sv
// Shared definitions for the two-digit countdown controller: state encoding,
// 7-segment patterns and the preset clamp helper.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Switch values above 9 are not valid BCD; treat them as 9
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/countdown_ctrl_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
module seg7_decode
    import countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup, no state
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown controller with load/start/pause buttons and a
// per-step prescaler.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | digits show the preset, waiting for start
//   RUN   | prescaler running, digits step down once per TICK_DIV cycles
//   PAUSE | digits and prescaler frozen, start or pause resumes
//   DONE  | countdown reached 00, start reloads the preset
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       busy,
    output logic       done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state, state_nxt;
    logic [3:0]    tens_nxt, ones_nxt;
    logic [7:0]    preset, preset_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          load_q, start_q, pause_q;
    logic          ev_load, ev_start, ev_pause;
    logic          tick;
    logic [7:0]    preset_in;
    logic [3:0]    tens_dec, ones_dec;
    logic          dec_zero, digits_zero;

    // One event per cycle: load beats start beats pause
    assign ev_load  = load & ~load_q;
    assign ev_start = start & ~start_q & ~ev_load;
    assign ev_pause = pause & ~pause_q & ~ev_load & ~ev_start;

    assign preset_in   = {clamp_bcd(preset_tens), clamp_bcd(preset_ones)};
    assign tick        = (state == ST_RUN) && (presc == PRESC_LAST);
    assign digits_zero = (tens == 4'd0) && (ones == 4'd0);

    // BCD step down with borrow from tens
    assign ones_dec = (ones == 4'd0) ? 4'd9 : ones - 4'd1;
    assign tens_dec = (ones == 4'd0) ? tens - 4'd1 : tens;
    assign dec_zero = (tens_dec == 4'd0) && (ones_dec == 4'd0);

    // Next-state, digit, preset and prescaler decisions
    always_comb begin
        state_nxt  = state;
        tens_nxt   = tens;
        ones_nxt   = ones;
        preset_nxt = preset;
        presc_nxt  = presc;
        if (ev_load) begin
            preset_nxt = preset_in;
            tens_nxt   = preset_in[7:4];
            ones_nxt   = preset_in[3:0];
            presc_nxt  = '0;
            state_nxt  = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ev_start) begin
                        if (digits_zero) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_RUN;
                            presc_nxt = '0;
                        end
                    end
                end
                ST_RUN: begin
                    // The prescaler keeps counting on the edge a pause lands,
                    // so the remainder after resume is exactly what was left
                    if (tick) begin
                        presc_nxt = '0;
                        tens_nxt  = tens_dec;
                        ones_nxt  = ones_dec;
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                    if (tick && dec_zero) begin
                        state_nxt = ST_DONE;
                    end else if (ev_pause) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (ev_start || ev_pause) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (ev_start) begin
                        tens_nxt = preset[7:4];
                        ones_nxt = preset[3:0];
                        if (preset != 8'h00) begin
                            state_nxt = ST_RUN;
                            presc_nxt = '0;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, datapath and button edge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tens    <= 4'd0;
            ones    <= 4'd0;
            preset  <= 8'h00;
            presc   <= '0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            tens    <= tens_nxt;
            ones    <= ones_nxt;
            preset  <= preset_nxt;
            presc   <= presc_nxt;
            load_q  <= load;
            start_q <= start;
            pause_q <= pause;
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_PAUSE);
    assign done = (state == ST_DONE);

    seg7_decode u_seg_tens (.bcd(tens), .seg(seg_tens));
    seg7_decode u_seg_ones (.bcd(ones), .seg(seg_ones));

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed and randomized checks of countdown_ctrl against an integer-valued
// behavioural model of the countdown.
module tb_countdown_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] preset_tens = 4'd0, preset_ones = 4'd0;
    logic [3:0] tens, ones;
    logic [6:0] seg_tens, seg_ones;
    logic       busy, done;

    int n_chk = 0;
    int n_fail = 0;

    // model: 0 idle, 1 run, 2 pause, 3 done; count held as 0..99
    int m_mode, m_val, m_pre, m_phase;
    bit m_lq, m_sq, m_pq;

    countdown_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause),
        .preset_tens(preset_tens), .preset_ones(preset_ones),
        .tens(tens), .ones(ones), .seg_tens(seg_tens), .seg_ones(seg_ones),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_step();
        bit el, es, ep;
        int pin;
        if (rst) begin
            m_mode = 0; m_val = 0; m_pre = 0; m_phase = 0;
            m_lq = 0; m_sq = 0; m_pq = 0;
            return;
        end
        el  = load && !m_lq;
        es  = start && !m_sq && !el;
        ep  = pause && !m_pq && !el && !es;
        pin = clamp9(int'(preset_tens)) * 10 + clamp9(int'(preset_ones));
        if (el) begin
            m_pre = pin; m_val = pin; m_phase = 0; m_mode = 0;
        end else begin
            case (m_mode)
                0: if (es) begin
                       if (m_val != 0) begin m_mode = 1; m_phase = 0; end
                       else m_mode = 3;
                   end
                1: begin
                       m_phase++;
                       if (m_phase == TD) begin
                           m_phase = 0;
                           m_val--;
                       end
                       if (m_val == 0) m_mode = 3;
                       else if (ep) m_mode = 2;
                   end
                2: if (es || ep) m_mode = 1;
                default: if (es) begin
                       m_val = m_pre;
                       if (m_pre != 0) begin m_mode = 1; m_phase = 0; end
                   end
            endcase
        end
        m_lq = load; m_sq = start; m_pq = pause;
    endtask

    task automatic cycle();
        int exp_digits;
        @(posedge clk);
        model_step();
        #1;
        exp_digits = (m_val / 10) * 16 + (m_val % 10);
        chk("digits", 32'({tens, ones}), 32'(exp_digits));
        chk("busy_done", 32'({busy, done}), {30'd0, (m_mode == 1 || m_mode == 2), (m_mode == 3)});
        chk("segs", 32'({seg_tens, seg_ones}), 32'({seg_ref(m_val / 10), seg_ref(m_val % 10)}));
    endtask

    task automatic pulse_load(input int t, input int o);
        preset_tens = 4'(t); preset_ones = 4'(o);
        load = 1'b1; cycle(); load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cycle(); pause = 1'b0;
    endtask

    initial begin
        // reset
        cycle(); cycle();
        chk("rst_digits", 32'({tens, ones}), 32'h00);
        chk("rst_segs", 32'({seg_tens, seg_ones}), 32'({7'b1000000, 7'b1000000}));
        chk("rst_flags", 32'({busy, done}), 32'h0);
        rst = 1'b0;
        cycle();

        // load 12, run to 00
        pulse_load(1, 2);
        chk("load12", 32'({tens, ones}), 32'h12);
        pulse_start();
        for (int i = 0; i < 48; i++) begin
            cycle();
            if (i == 3)  chk("step11", 32'({tens, ones}), 32'h11);
            if (i == 7)  chk("step10", 32'({tens, ones}), 32'h10);
            if (i == 11) chk("step09", 32'({tens, ones}), 32'h09);
            if (i == 46) chk("done_early", 32'({busy, done}), 32'h2);
            if (i == 47) chk("done_48", 32'({busy, done}), 32'h1);
        end

        // clamp and borrow
        pulse_load(15, 0);
        chk("clamp90", 32'({tens, ones}), 32'h90);
        pulse_start();
        repeat (TD) cycle();
        chk("borrow89", 32'({tens, ones}), 32'h89);

        // pause two cycles after a step, resume with two cycles left
        pulse_load(0, 5);
        pulse_start();
        repeat (TD) cycle();
        chk("step04", 32'({tens, ones}), 32'h04);
        cycle();
        pulse_pause();
        repeat (10) cycle();
        chk("frozen", 32'({tens, ones}), 32'h04);
        chk("paused_busy", 32'(busy), 32'h1);
        pulse_start();
        cycle();
        chk("resume_hold", 32'({tens, ones}), 32'h04);
        cycle();
        chk("resume_step", 32'({tens, ones}), 32'h03);

        // simultaneous events: load wins
        pulse_load(3, 0);
        pulse_start();
        load = 1'b1; start = 1'b1; pause = 1'b1;
        cycle();
        load = 1'b0; start = 1'b0; pause = 1'b0;
        chk("simul_digits", 32'({tens, ones}), 32'h30);
        chk("simul_flags", 32'({busy, done}), 32'h0);
        cycle();

        // zero preset and restart from DONE
        pulse_load(0, 0);
        pulse_start();
        chk("zero_done", 32'(done), 32'h1);
        pulse_load(0, 3);
        pulse_start();
        repeat (12) cycle();
        chk("run03_done", 32'(done), 32'h1);
        pulse_start();
        chk("restart03", 32'({busy, tens, ones}), 32'h103);
        repeat (12) cycle();
        chk("restart_done", 32'(done), 32'h1);

        // mid-run reset
        pulse_load(4, 7);
        pulse_start();
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mrst_digits", 32'({tens, ones}), 32'h00);
        chk("mrst_segs", 32'({seg_tens, seg_ones}), 32'({7'b1000000, 7'b1000000}));
        chk("mrst_flags", 32'({busy, done}), 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            load        = ($urandom_range(0, 39) == 0);
            start       = ($urandom_range(0, 5) == 0);
            pause       = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            preset_tens = 4'($urandom_range(0, 15));
            preset_ones = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Two-digit countdown timer controller that sequences a BCD down-counter through load, run, pause and expiry, with per-second stepping from an internal prescaler. It sits between the board push-buttons and preset switches and the two 7-segment digits. It takes over the free-running single-digit down-count with a controlled, restartable 00–99 countdown.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per count step; legal range ≥ 2. Benches use 4.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- load  in  1  level input; a rising edge latches the preset
- start  in  1  level input; a rising edge starts or resumes the count
- pause  in  1  level input; a rising edge pauses or resumes the count
- preset_tens  in  4  preset tens digit; values 10–15 clamp to 9
- preset_ones  in  4  preset ones digit; values 10–15 clamp to 9
- tens  out  4  current tens digit, BCD
- ones  out  4  current ones digit, BCD
- seg_tens  out  7  active-low segments {g,f,e,d,c,b,a} for tens
- seg_ones  out  7  active-low segments {g,f,e,d,c,b,a} for ones
- busy  out  1  high in RUN and PAUSE
- done  out  1  high in DONE

## Operation
- Edge detect: each of load, start and pause has a 1-bit registered copy; event = in & ~in_q. The copy resets to 0, so an input held high through reset release produces an event on the first cycle after reset.
- Preset register: holds the clamped {tens, ones} captured on a load event.
- Priority when events coincide: load > start > pause. Only one event acts per cycle; the others are dropped.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE
  - load: latch the preset and copy it to the digits; stay in IDLE.
  - start: if the digits are nonzero, go to RUN with the prescaler cleared; if they are 00, go to DONE.
  - pause: ignored.
- RUN
  - On each tick, decrement the digits by one, BCD-style: ones 0→9 with a tens borrow; otherwise ones−1.
  - A tick that yields 00 moves to DONE in the same cycle.
  - pause: go to PAUSE and hold the prescaler value.
  - load: reload the preset, clear the prescaler, go to IDLE.
  - start: ignored.
- PAUSE
  - start or pause: go to RUN; the prescaler resumes from its held value.
  - load: reload the preset and go to IDLE.
  - Digits are frozen.
- DONE
  - Digits hold 00.
  - start: reload the preset register into the digits; go to RUN if nonzero, otherwise stay in DONE.
  - load: latch the new preset and go to IDLE.
  - pause: ignored.
- Tick: the prescaler counts 0..TICK_DIV−1 only in RUN. Tick = 1 when prescaler == TICK_DIV−1, and the prescaler wraps to 0.
- Segment code: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, other=1111111.

## Timing
- Reset (synchronous, sampled on a clk edge): state IDLE; digits 00; preset 00; prescaler 0; edge registers 0; busy 0; done 0; seg_tens = seg_ones = 1000000.
- A rising input first sampled high at edge N updates state, digits and preset at edge N; the new values are visible after edge N.
- Count steps: RUN entered at edge N gives the first decrement at edge N+TICK_DIV, then every TICK_DIV cycles.
- Pause and resume: the step period resumes with the remaining cycles preserved.
- Digit outputs, busy and done are registered. The seg_* outputs are combinational decodes of the registered digits, so there is zero extra latency.
- Reset asserted in any state returns to IDLE at that edge, overriding all events.

## Structure
- Package countdown_pkg holds:
  - the state encoding as 2-bit constants: IDLE=00, RUN=01, PAUSE=10, DONE=11;
  - the ten segment patterns and the blank pattern;
  - the BCD clamp function.
- Sub-module seg7_decode: 4-bit BCD in, 7-bit active-low out, purely combinational. It is instantiated twice.
- The controller FSM, prescaler, edge detectors and BCD counter live in countdown_ctrl.

## Test plan
- Reset, load, start: reset; preset 1/2; pulse load, then start. Required: digits 12→11→10→09 every 4 cycles; done=1 and busy=0 exactly 48 cycles after entering RUN.
- Borrow and clamp: preset tens=15, ones=0. Required: load shows 90. After start, the first step gives 89, not 8F.
- Pause mid-step: RUN from 05; pulse pause 2 cycles after a step. Required: digits frozen and busy=1 for 10 cycles. After pulsing start, the next step occurs exactly 2 cycles later (4−2).
- Simultaneous events: in RUN at 30, raise load, start and pause on the same cycle. Required: load wins; state IDLE, digits 30 (preset), busy=0.
- Zero preset and restart: load 00, start. Required: DONE next edge, done=1. Then load 03, start from DONE; 12 cycles later DONE again.
- Mid-run reset: assert rst during RUN at 47. Required: next edge gives digits 00, seg_* = 1000000, busy=0, done=0, IDLE.
